// File: rtl/fir_pkg.sv
// Shared definitions for the serial FIR controller and its sample feeder:
// FSM state encoding, a ceiling-log2 helper and the FIR busy-window length.
package fir_pkg;

  // Feeder FSM states; explicit encoding so the illegal code 2'b11 is easy to spot
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10
  } fsm_state_t;

  // Default tap count, matching the FIR controller build
  localparam int DEFAULT_NUM_COEF = 17;

  // Cycles the FIR controller needs from val_in to val_out
  localparam int FIR_BUSY_WINDOW = DEFAULT_NUM_COEF + 2;

  // Ceiling log2, usable in constant expressions
  function automatic int log2_ceil(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

  // Busy window for an arbitrary tap count
  function automatic int busy_window(input int num_coef);
    return num_coef + 2;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO. Writes beyond full and reads of an empty FIFO are
// ignored, so the caller never corrupts occupancy. Read data is the head entry,
// which the consumer captures into its own register when it pops.
module sample_fifo
  import fir_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  localparam int PTR_W = log2_ceil(DEPTH),
  localparam int CNT_W = log2_ceil(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              wr_fire;
  logic              rd_fire;

  // Full/empty come straight from the registered count, i.e. the pre-read
  // occupancy: a write offered while full is refused even if a pop happens.
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;
  assign rd_data = mem[rd_ptr_reg];

  // Storage array; no reset so it maps onto plain RAM
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (rd_fire) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  // Occupancy count tracks simultaneous push and pop
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      case ({wr_fire, rd_fire})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/fir_sample_feeder.sv
// Upstream driver for the serial FIR controller. Buffers incoming samples,
// strobes the filter with one sample at a time only while it is idle, captures
// each result, and flags a sticky watchdog error if the filter never answers.
module fir_sample_feeder
  import fir_pkg::*;
#(
  parameter int Num_coef    = DEFAULT_NUM_COEF,
  parameter int DATA_W      = 16,
  parameter int OUT_W       = 36,
  parameter int FIFO_DEPTH  = 4,
  parameter int WDOG_MARGIN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_val,
  output logic              din_rdy,
  output logic [DATA_W-1:0] filt_din,
  output logic              filt_val_in,
  input  logic              filt_val_out,
  input  logic [OUT_W-1:0]  filt_dout,
  output logic [OUT_W-1:0]  dout,
  output logic              dout_val,
  output logic              busy,
  output logic              wdog_err
);

  // Cycles after the strobe at which a missing answer is declared a timeout
  localparam int WDOG_LIMIT = busy_window(Num_coef) + WDOG_MARGIN;
  localparam int WDOG_W     = log2_ceil(WDOG_LIMIT) + 1;

  fsm_state_t        state_reg;
  logic [DATA_W-1:0] filt_din_reg;
  logic              filt_val_in_reg;
  logic [OUT_W-1:0]  dout_reg;
  logic              dout_val_reg;
  logic              busy_reg;
  logic              wdog_err_reg;
  logic [WDOG_W-1:0] wdog_cnt_reg;

  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_pop;

  // The head is popped in the same cycle the FSM latches it into filt_din
  assign fifo_pop = (state_reg == ST_IDLE) && !fifo_empty;
  assign din_rdy  = !fifo_full;

  sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (din_val),
    .wr_data (din),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Feeder FSM with registered outputs and watchdog. The watchdog counts cycles
  // since the strobe: it is cleared as the FSM enters ISSUE, so it reads 0 in
  // the strobe cycle and k in the k-th cycle after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      filt_din_reg    <= '0;
      filt_val_in_reg <= 1'b0;
      dout_reg        <= '0;
      dout_val_reg    <= 1'b0;
      busy_reg        <= 1'b0;
      wdog_err_reg    <= 1'b0;
      wdog_cnt_reg    <= '0;
    end else begin
      filt_val_in_reg <= 1'b0;
      dout_val_reg    <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (!fifo_empty) begin
            filt_din_reg    <= fifo_rd_data;
            filt_val_in_reg <= 1'b1;
            busy_reg        <= 1'b1;
            wdog_cnt_reg    <= '0;
            state_reg       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wdog_cnt_reg <= wdog_cnt_reg + 1'b1;
          state_reg    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (filt_val_out) begin
            dout_reg     <= filt_dout;
            dout_val_reg <= 1'b1;
            busy_reg     <= 1'b0;
            state_reg    <= ST_IDLE;
          end else if (wdog_cnt_reg == WDOG_W'(WDOG_LIMIT - 1)) begin
            wdog_err_reg <= 1'b1;
            busy_reg     <= 1'b0;
            state_reg    <= ST_IDLE;
          end else begin
            wdog_cnt_reg <= wdog_cnt_reg + 1'b1;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign filt_din    = filt_din_reg;
  assign filt_val_in = filt_val_in_reg;
  assign dout        = dout_reg;
  assign dout_val    = dout_val_reg;
  assign busy        = busy_reg;
  assign wdog_err    = wdog_err_reg;

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Directed bench for fir_sample_feeder paired with a behavioural FIR controller
// that answers Num_coef+2 cycles after each strobe with result = sample * 17.
module tb_fir_sample_feeder;

  localparam int NUM_COEF    = 17;
  localparam int DATA_W      = 16;
  localparam int OUT_W       = 36;
  localparam int FIFO_DEPTH  = 4;
  localparam int WDOG_MARGIN = 4;
  localparam int RESP_DELAY  = NUM_COEF + 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] din = '0;
  logic              din_val = 1'b0;
  logic              din_rdy;
  logic [DATA_W-1:0] filt_din;
  logic              filt_val_in;
  logic              filt_val_out;
  logic [OUT_W-1:0]  filt_dout;
  logic [OUT_W-1:0]  dout;
  logic              dout_val;
  logic              busy;
  logic              wdog_err;

  // FIR controller model and spurious-strobe injection
  logic              model_en = 1'b1;
  logic              model_val = 1'b0;
  logic [OUT_W-1:0]  model_data = '0;
  logic [DATA_W-1:0] model_hold = '0;
  int                model_pend = 0;
  logic              spur = 1'b0;
  logic [OUT_W-1:0]  spur_data = '0;

  assign filt_val_out = model_val | spur;
  assign filt_dout    = spur ? spur_data : model_data;

  fir_sample_feeder #(
    .Num_coef    (NUM_COEF),
    .DATA_W      (DATA_W),
    .OUT_W       (OUT_W),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .WDOG_MARGIN (WDOG_MARGIN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .din_val      (din_val),
    .din_rdy      (din_rdy),
    .filt_din     (filt_din),
    .filt_val_in  (filt_val_in),
    .filt_val_out (filt_val_out),
    .filt_dout    (filt_dout),
    .dout         (dout),
    .dout_val     (dout_val),
    .busy         (busy),
    .wdog_err     (wdog_err)
  );

  always #5 clk = ~clk;

  // Model: strobe sampled at edge E -> val_out high during the cycle after edge E+18
  always @(posedge clk) begin
    model_val <= 1'b0;
    if (filt_val_in === 1'b1) begin
      model_pend <= RESP_DELAY - 1;
      model_hold <= filt_din;
    end else if (model_pend > 0) begin
      model_pend <= model_pend - 1;
      if (model_pend == 1 && model_en) begin
        model_val  <= 1'b1;
        model_data <= 36'(model_hold) * 36'(NUM_COEF);
      end
    end
  end

  // Cycle counter and event recorders
  int               cyc = 0;
  int               strobe_q[$];
  logic [OUT_W-1:0] res_q[$];
  int               rescyc_q[$];
  int               wdog_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (filt_val_in === 1'b1) strobe_q.push_back(cyc);
    if (dout_val === 1'b1) begin
      res_q.push_back(dout);
      rescyc_q.push_back(cyc);
    end
    if (wdog_err === 1'b1 && wdog_cyc < 0) wdog_cyc = cyc;
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    strobe_q.delete();
    res_q.delete();
    rescyc_q.delete();
  endtask

  task automatic wait_results(input int n, input int budget);
    int b;
    b = budget;
    while (res_q.size() < n && b > 0) begin
      tick(1);
      b--;
    end
  endtask

  logic [DATA_W-1:0] burst_din [6] = '{16'h0001, 16'h0002, 16'h0010, 16'h0FFF, 16'hFFFF, 16'h8000};
  logic [OUT_W-1:0]  burst_exp [6] = '{36'h11, 36'h22, 36'h110, 36'h10FEF, 36'h10FFEF, 36'h88000};

  initial begin
    int w;
    int stall;
    int accept_cyc;
    int guard;

    // Reset
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    check("rst_din_rdy", din_rdy, 1);
    check("rst_busy", busy, 0);
    check("rst_filt_val_in", filt_val_in, 0);
    check("rst_dout_val", dout_val, 0);
    check("rst_dout", dout, 0);
    check("rst_wdog_err", wdog_err, 0);
    check("rst_filt_din", filt_din, 0);
    clear_logs();
    $display("step reset done at cycle %0d", cyc);

    // Single sample 0x0100
    w = cyc;
    din = 16'h0100;
    din_val = 1'b1;
    tick(1);
    din_val = 1'b0;
    tick(4);
    check("single_busy", busy, 1);
    check("single_filt_din", filt_din, 16'h0100);
    wait_results(1, 40);
    check("single_res_count", res_q.size(), 1);
    check("single_strobe_count", strobe_q.size(), 1);
    check("single_strobe_cyc", strobe_q[0], w + 2);
    check("single_res_cyc", rescyc_q[0], w + 22);
    check("single_res", res_q[0], 36'h1100);
    check("single_busy_after", busy, 0);
    $display("step single sample dout=%0h at cycle %0d", res_q[0], rescyc_q[0]);
    tick(3);
    clear_logs();

    // Six samples offered back to back; source holds while din_rdy is low
    w = cyc;
    stall = 0;
    accept_cyc = -1;
    for (int i = 0; i < 6; i++) begin
      din = burst_din[i];
      din_val = 1'b1;
      guard = 0;
      while (din_rdy !== 1'b1 && guard < 100) begin
        stall++;
        guard++;
        tick(1);
      end
      if (i == 5) accept_cyc = cyc;
      tick(1);
    end
    din_val = 1'b0;
    wait_results(6, 200);
    check("burst_stall_cycles", stall, 18);
    check("burst_accept6_cyc", accept_cyc, w + 23);
    check("burst_res_count", res_q.size(), 6);
    check("burst_first_strobe", strobe_q[0], w + 2);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("burst_res%0d", i), res_q[i], burst_exp[i]);
      $display("step burst result %0d dout=%0h at cycle %0d", i, res_q[i], rescyc_q[i]);
    end
    for (int i = 1; i < 6; i++) begin
      check($sformatf("burst_spacing%0d", i), strobe_q[i] - strobe_q[i-1], 21);
    end
    check("burst_last_latency", rescyc_q[5] - strobe_q[5], 20);
    tick(3);
    clear_logs();

    // Watchdog: filter silent for sample A, answers sample B
    model_en = 1'b0;
    w = cyc;
    din = 16'h0A0A;
    din_val = 1'b1;
    tick(1);
    din = 16'h0B0B;
    tick(1);
    din_val = 1'b0;
    guard = 0;
    while (wdog_cyc < 0 && guard < 60) begin
      tick(1);
      guard++;
    end
    model_en = 1'b1;
    wait_results(1, 60);
    check("wdog_cyc", wdog_cyc, w + 25);
    check("wdog_strobe_count", strobe_q.size(), 2);
    check("wdog_next_strobe", strobe_q[1], w + 26);
    check("wdog_res_count", res_q.size(), 1);
    check("wdog_res", res_q[0], 36'hBBBB);
    check("wdog_res_cyc", rescyc_q[0], w + 46);
    check("wdog_sticky", wdog_err, 1);
    $display("step watchdog err at cycle %0d, next dout=%0h", wdog_cyc, res_q[0]);
    tick(2);
    clear_logs();

    // Spurious result strobe while idle
    spur_data = 36'h0DEADBEEF;
    spur = 1'b1;
    tick(1);
    spur = 1'b0;
    tick(3);
    check("spur_res_count", res_q.size(), 0);
    check("spur_dout_kept", dout, 36'hBBBB);
    check("spur_busy", busy, 0);
    check("spur_strobes", strobe_q.size(), 0);
    $display("step spurious filt_val_out ignored, dout=%0h", dout);
    clear_logs();

    // Reset while waiting on the filter, second sample queued
    w = cyc;
    din = 16'h0123;
    din_val = 1'b1;
    tick(1);
    din = 16'h0456;
    tick(1);
    din_val = 1'b0;
    tick(8);
    check("rstwait_busy_before", busy, 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rstwait_busy", busy, 0);
    check("rstwait_wdog_clr", wdog_err, 0);
    check("rstwait_dout", dout, 0);
    check("rstwait_din_rdy", din_rdy, 1);
    tick(30);
    check("rstwait_late_res", res_q.size(), 0);
    check("rstwait_strobes", strobe_q.size(), 1);
    $display("step reset in WAIT: strobes=%0d results=%0d", strobe_q.size(), res_q.size());

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
